strand_select_stage: RTL and testbench
======================================

Name: strand_select_stage

Overview:
- Sits directly downstream of the per-strand FSMs, one FSM per strand.
- Each cycle it round-robin arbitrates among strands raising issue requests and returns a one-hot grant.
- It muxes the winner's instruction, pc, lane and offset into a pipeline register that feeds decode.
- It owns decode-side stall and per-strand flush handling for the registered slot.

Parameters:
- NUM_STRANDS, 4, number of strands arbitrated. Legal values: 2 or 4.
- SID_WIDTH, 2, width of the strand id. Equals log2(NUM_STRANDS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- issue_request_i  in  NUM_STRANDS  per-strand issue request; bit n belongs to strand n.
- instruction_i  in  32*NUM_STRANDS  per-strand instruction; strand n occupies bits [32n+31:32n].
- pc_i  in  32*NUM_STRANDS  per-strand pc, same packing as instruction_i.
- reg_lane_select_i  in  4*NUM_STRANDS  per-strand vector lane.
- strided_offset_i  in  32*NUM_STRANDS  per-strand strided offset.
- flush_i  in  NUM_STRANDS  per-strand rollback flush.
- stall_i  in  1  decode cannot accept a new instruction this cycle.
- grant_o  out  NUM_STRANDS  one-hot grant, combinational, same cycle as the request.
- instruction_valid_o  out  1  registered slot holds a live instruction.
- instruction_o  out  32  registered instruction.
- pc_o  out  32  registered pc.
- reg_lane_select_o  out  4  registered lane.
- strided_offset_o  out  32  registered offset.
- strand_id_o  out  SID_WIDTH  strand that owns the registered slot.

Behaviour:
Arbitration
- Eligible strands: eligible[n] = issue_request_i[n] & ~flush_i[n].
- Priority pointer last_ff holds the id of the most recent granted strand.
- Search order: last_ff+1, last_ff+2, … modulo NUM_STRANDS, wrapping. The first eligible strand wins.
- grant_o is one-hot or all zero.
- grant_o = 0 when stall_i=1 or when no strand is eligible.
- last_ff updates to the winner only on a cycle with a nonzero grant. Otherwise it holds.

Pipeline register (1-cycle latency, grant cycle → outputs on the next edge)
- Nonzero grant: capture the winner's instruction, pc, lane and offset. strand_id_o <= winner id; instruction_valid_o <= 1.
- No grant and stall_i=0: instruction_valid_o <= 0; instruction_o <= 0 (NOP). Other data outputs hold.
- stall_i=1: every output holds its value, except when the flush rule below applies.
- Flush: if flush_i[strand_id_o]=1 and instruction_valid_o=1, then instruction_valid_o <= 0 and instruction_o <= 0. This applies even while stall_i=1, so flush beats stall.
- Flush with a simultaneous nonzero grant to a different strand: the new capture wins and valid=1.
- A flushed strand is never granted in the same cycle, because of the eligibility mask.

Reset
- Asynchronous assertion: instruction_valid_o=0; instruction_o, pc_o, reg_lane_select_o, strided_offset_o, strand_id_o all 0.
- last_ff = NUM_STRANDS-1, so strand 0 has first priority after reset.
- grant_o = 0 while reset=1.
- Reset mid-stall drops the held instruction.

Width rules
- Pointer increment wraps modulo NUM_STRANDS; there is no out-of-range id.
- Data paths are bit-exact copies. No arithmetic on data.

Optional Feature:
Macro: STRAND_SELECT_PERF_EN.
- Defined: adds internal 64-bit counters, reset to 0.
  - idle_cycle_count increments each cycle with no grant and stall_i=0.
  - stall_cycle_count increments each cycle with stall_i=1.
  - issue_count[n] increments on each grant to strand n.
  - No ports change. The bench reads the counters hierarchically.
- Undefined: no counters and no extra logic. Port list and functional behaviour are identical.

Test Plan:
- Reset released, issue_request_i=4'b1111 held for 8 cycles, stall_i=0 → grants 0,1,2,3,0,1,2,3. strand_id_o follows one cycle later and valid stays 1.
- issue_request_i=4'b1010 with last_ff=3 → grant 1, then 3, then 1. Unrequested strands are never granted.
- Strand 2 granted with instruction_i[2]=32'hC012_3456, pc 32'h100. Next cycle stall_i=1 for 3 cycles → outputs hold 32'hC012_3456, pc 32'h100, valid=1, grant_o=0. On release, arbitration resumes at strand 3.
- Slot holds strand 1 with valid=1 and stall_i=1, then flush_i=4'b0010 → next edge valid=0, instruction_o=0. flush_i[1] with issue_request_i[1]=1 and only strand 1 requesting → grant_o=0.
- reset pulsed asynchronously mid-cycle while valid=1 → outputs clear immediately without a clock edge; first post-reset grant goes to strand 0.
- With STRAND_SELECT_PERF_EN, run 10 cycles: 4 grants, 3 idle, 3 stall → issue counts summed = 4, idle_cycle_count=3, stall_cycle_count=3.

Source files
------------

// File: rtl/strand_select_stage.sv
// strand_select_stage: round-robin issue arbiter across per-strand FSMs plus the
// single pipeline register that feeds decode. Owns decode-side stall and
// per-strand flush handling for the registered slot.
//
// Optional build feature: define STRAND_SELECT_PERF_EN to add internal 64-bit
// performance counters (idle_cycle_count, stall_cycle_count, issue_count[n]).
// Ports and functional behaviour are identical with or without it.
//
// Handshake: issue_request_i[n] is strand n's "valid"; ~stall_i is decode's
// "ready". A transfer happens only on a cycle where grant_o[n]=1, which implies
// request, no flush on that strand, and ready. The slot never changes while
// stall_i=1 except for a flush of the strand that owns it.
module strand_select_stage #(
    parameter int NUM_STRANDS = 4,
    parameter int SID_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_STRANDS-1:0]    issue_request_i,
    input  logic [32*NUM_STRANDS-1:0] instruction_i,
    input  logic [32*NUM_STRANDS-1:0] pc_i,
    input  logic [4*NUM_STRANDS-1:0]  reg_lane_select_i,
    input  logic [32*NUM_STRANDS-1:0] strided_offset_i,
    input  logic [NUM_STRANDS-1:0]    flush_i,
    input  logic                      stall_i,
    output logic [NUM_STRANDS-1:0]    grant_o,
    output logic                      instruction_valid_o,
    output logic [31:0]               instruction_o,
    output logic [31:0]               pc_o,
    output logic [3:0]                reg_lane_select_o,
    output logic [31:0]               strided_offset_o,
    output logic [SID_WIDTH-1:0]      strand_id_o
);

    logic [NUM_STRANDS-1:0] eligible;
    logic [SID_WIDTH-1:0]   last_q, last_d;
    logic [SID_WIDTH-1:0]   probe;
    logic [SID_WIDTH-1:0]   winner;
    logic                   found;
    logic                   grant_valid;

    logic                   valid_q, valid_d;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            pc_q, pc_d;
    logic [3:0]             lane_q, lane_d;
    logic [31:0]            off_q, off_d;
    logic [SID_WIDTH-1:0]   sid_q, sid_d;

    // Round-robin search starting one past the last winner; ids wrap naturally
    // because NUM_STRANDS is a power of two equal to 2**SID_WIDTH.
    always_comb begin
        eligible = issue_request_i & ~flush_i;
        winner   = '0;
        found    = 1'b0;
        probe    = '0;
        for (int i = 1; i <= NUM_STRANDS; i++) begin
            probe = last_q + SID_WIDTH'(i);
            if (!found && eligible[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
        grant_valid = found & ~stall_i & ~reset;
        grant_o     = grant_valid ? (NUM_STRANDS'(1) << winner) : '0;
        last_d      = grant_valid ? winner : last_q;
    end

    // Next-state of the decode slot: capture beats flush, flush beats stall.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        lane_d  = lane_q;
        off_d   = off_q;
        sid_d   = sid_q;
        if (grant_valid) begin
            valid_d = 1'b1;
            instr_d = instruction_i[32*winner +: 32];
            pc_d    = pc_i[32*winner +: 32];
            lane_d  = reg_lane_select_i[4*winner +: 4];
            off_d   = strided_offset_i[32*winner +: 32];
            sid_d   = winner;
        end else if (!stall_i) begin
            valid_d = 1'b0;
            instr_d = '0;
        end else if (valid_q && flush_i[sid_q]) begin
            valid_d = 1'b0;
            instr_d = '0;
        end
    end

    // Slot and priority pointer registers; pointer resets so strand 0 goes first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= SID_WIDTH'(NUM_STRANDS - 1);
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            lane_q  <= '0;
            off_q   <= '0;
            sid_q   <= '0;
        end else begin
            last_q  <= last_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            lane_q  <= lane_d;
            off_q   <= off_d;
            sid_q   <= sid_d;
        end
    end

    assign instruction_valid_o = valid_q;
    assign instruction_o       = instr_q;
    assign pc_o                = pc_q;
    assign reg_lane_select_o   = lane_q;
    assign strided_offset_o    = off_q;
    assign strand_id_o         = sid_q;

`ifdef STRAND_SELECT_PERF_EN
    logic [63:0] idle_cycle_count;
    logic [63:0] stall_cycle_count;
    logic [63:0] issue_count [NUM_STRANDS];

    // Utilisation counters: idle = ready but nothing issued, stall = not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cycle_count  <= '0;
            stall_cycle_count <= '0;
            for (int n = 0; n < NUM_STRANDS; n++) begin
                issue_count[n] <= '0;
            end
        end else begin
            if (stall_i) begin
                stall_cycle_count <= stall_cycle_count + 64'd1;
            end else if (!grant_valid) begin
                idle_cycle_count <= idle_cycle_count + 64'd1;
            end
            if (grant_valid) begin
                issue_count[winner] <= issue_count[winner] + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_strand_select_stage.sv
// Directed testbench for strand_select_stage: hand-computed grant sequences,
// slot contents, stall hold, flush, async reset and (when built with
// STRAND_SELECT_PERF_EN) the performance counters.
module tb_strand_select_stage;
    localparam int N  = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      issue_request_i;
    logic [32*N-1:0]   instruction_i;
    logic [32*N-1:0]   pc_i;
    logic [4*N-1:0]    reg_lane_select_i;
    logic [32*N-1:0]   strided_offset_i;
    logic [N-1:0]      flush_i;
    logic              stall_i;
    logic [N-1:0]      grant_o;
    logic              instruction_valid_o;
    logic [31:0]       instruction_o;
    logic [31:0]       pc_o;
    logic [3:0]        reg_lane_select_o;
    logic [31:0]       strided_offset_o;
    logic [SW-1:0]     strand_id_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] s_instr [N];
    logic [31:0] s_pc    [N];
    logic [3:0]  s_lane  [N];
    logic [31:0] s_off   [N];

    strand_select_stage #(.NUM_STRANDS(N), .SID_WIDTH(SW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .issue_request_i     (issue_request_i),
        .instruction_i       (instruction_i),
        .pc_i                (pc_i),
        .reg_lane_select_i   (reg_lane_select_i),
        .strided_offset_i    (strided_offset_i),
        .flush_i             (flush_i),
        .stall_i             (stall_i),
        .grant_o             (grant_o),
        .instruction_valid_o (instruction_valid_o),
        .instruction_o       (instruction_o),
        .pc_o                (pc_o),
        .reg_lane_select_o   (reg_lane_select_o),
        .strided_offset_o    (strided_offset_o),
        .strand_id_o         (strand_id_o)
    );

    // Clock and hard time limit.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_data();
        for (int n = 0; n < N; n++) begin
            instruction_i[32*n +: 32]    = s_instr[n];
            pc_i[32*n +: 32]             = s_pc[n];
            reg_lane_select_i[4*n +: 4]  = s_lane[n];
            strided_offset_i[32*n +: 32] = s_off[n];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input int n);
        chk({tag, "_valid"}, 64'(instruction_valid_o), 64'd1);
        chk({tag, "_sid"},   64'(strand_id_o),         64'(n));
        chk({tag, "_instr"}, 64'(instruction_o),       64'(s_instr[n]));
        chk({tag, "_pc"},    64'(pc_o),                64'(s_pc[n]));
        chk({tag, "_lane"},  64'(reg_lane_select_o),   64'(s_lane[n]));
        chk({tag, "_off"},   64'(strided_offset_o),    64'(s_off[n]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(instruction_valid_o), 64'd0);
        chk({tag, "_instr"}, 64'(instruction_o),       64'd0);
        chk({tag, "_pc"},    64'(pc_o),                64'd0);
        chk({tag, "_lane"},  64'(reg_lane_select_o),   64'd0);
        chk({tag, "_off"},   64'(strided_offset_o),    64'd0);
        chk({tag, "_sid"},   64'(strand_id_o),         64'd0);
    endtask

    // Issue one cycle: drive request, check the combinational grant, clock it.
    task automatic issue(input string tag, input logic [N-1:0] req, input logic [N-1:0] exp_grant);
        issue_request_i = req;
        #1;
        chk({tag, "_grant"}, 64'(grant_o), 64'(exp_grant));
        tick();
    endtask

    initial begin
        logic [3:0] rr_seq [8];
        logic [3:0] alt_seq [3];
        int         alt_id [3];
        rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        alt_seq = '{4'b0010, 4'b1000, 4'b0010};
        alt_id  = '{1, 3, 1};

        for (int n = 0; n < N; n++) begin
            s_instr[n] = 32'hA000_0000 | 32'(n);
            s_pc[n]    = 32'h0000_1000 + 32'(4 * n);
            s_lane[n]  = 4'(n + 5);
            s_off[n]   = 32'h0F00_0000 | 32'(16 * n);
        end
        pack_data();
        reset           = 1'b1;
        issue_request_i = 4'b1111;
        flush_i         = '0;
        stall_i         = 1'b0;

        // Reset state, requests present but no grant while in reset.
        #3;
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_grant", 64'(grant_o), 64'd0);
        chk_zero("rst_hold");
        reset = 1'b0;

        // All strands requesting: 0,1,2,3,0,1,2,3 with slot one cycle later.
        for (int i = 0; i < 8; i++) begin
            issue($sformatf("rr%0d", i), 4'b1111, rr_seq[i]);
            chk_slot($sformatf("rr%0d_slot", i), i % 4);
        end

        // Strands 1 and 3 only, pointer at 3: 1, 3, 1.
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("alt%0d", i), 4'b1010, alt_seq[i]);
            chk_slot($sformatf("alt%0d_slot", i), alt_id[i]);
        end

        // Strand 2 captured, then held for 3 stalled cycles.
        s_instr[2] = 32'hC012_3456;
        s_pc[2]    = 32'h0000_0100;
        pack_data();
        issue("s2", 4'b0100, 4'b0100);
        chk_slot("s2_slot", 2);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("stall%0d", i), 4'b1111, 4'b0000);
            chk($sformatf("stall%0d_instr", i), 64'(instruction_o), 64'hC012_3456);
            chk($sformatf("stall%0d_pc", i), 64'(pc_o), 64'h100);
            chk($sformatf("stall%0d_valid", i), 64'(instruction_valid_o), 64'd1);
            chk($sformatf("stall%0d_sid", i), 64'(strand_id_o), 64'd2);
        end
        stall_i = 1'b0;
        issue("resume", 4'b1111, 4'b1000);
        chk_slot("resume_slot", 3);

        // Flush beats stall for the slot owner.
        issue("f_load", 4'b0010, 4'b0010);
        chk_slot("f_load_slot", 1);
        stall_i = 1'b1;
        flush_i = 4'b0010;
        issue("f_stall", 4'b0010, 4'b0000);
        chk("f_stall_valid", 64'(instruction_valid_o), 64'd0);
        chk("f_stall_instr", 64'(instruction_o), 64'd0);
        chk("f_stall_pc", 64'(pc_o), 64'(s_pc[1]));
        stall_i = 1'b0;
        issue("f_mask", 4'b0010, 4'b0000);
        chk("f_mask_valid", 64'(instruction_valid_o), 64'd0);

        // Flush of the owner with a grant to another strand: capture wins.
        flush_i = '0;
        issue("f_reload", 4'b0010, 4'b0010);
        chk_slot("f_reload_slot", 1);
        flush_i = 4'b0010;
        issue("f_other", 4'b0011, 4'b0001);
        chk_slot("f_other_slot", 0);
        flush_i = '0;

        // Asynchronous reset mid-cycle with a live slot.
        issue_request_i = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk_zero("arst");
        #1;
        reset = 1'b0;
        issue("post_rst", 4'b1111, 4'b0001);
        chk_slot("post_rst_slot", 0);

        // No request, no stall: bubble with NOP, other data holds.
        issue("bubble", 4'b0000, 4'b0000);
        chk("bubble_valid", 64'(instruction_valid_o), 64'd0);
        chk("bubble_instr", 64'(instruction_o), 64'd0);
        chk("bubble_pc", 64'(pc_o), 64'(s_pc[0]));
        chk("bubble_sid", 64'(strand_id_o), 64'd0);

        // Ten cycles: 4 grants, 3 idle, 3 stalled.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue($sformatf("perf_g%0d", i), 4'b1111, rr_seq[i]);
        end
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("perf_i%0d", i), 4'b0000, 4'b0000);
        end
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("perf_s%0d", i), 4'b1111, 4'b0000);
        end
        stall_i = 1'b0;
`ifdef STRAND_SELECT_PERF_EN
        chk("perf_issue_sum", dut.issue_count[0] + dut.issue_count[1] +
            dut.issue_count[2] + dut.issue_count[3], 64'd4);
        chk("perf_issue0", dut.issue_count[0], 64'd1);
        chk("perf_issue3", dut.issue_count[3], 64'd1);
        chk("perf_idle", dut.idle_cycle_count, 64'd3);
        chk("perf_stall", dut.stall_cycle_count, 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
